stopwatch_sequencer: RTL and testbench

- Single-clock controller for the stopwatch/alarm datapath: takes raw start/stop/pause and clear buttons, a centisecond tick pulse and a speed select.
- Runs the IDLE/RUN/PAUSE/ALARM state machine and owns the elapsed-time counter `t` that feeds `sevenSegmentDisplay`.
- Replaces gating of derived clocks with one 50 MHz clock plus a `tick` enable from the clock divider.

---
 rtl/timer_pkg.sv | 15 +
 rtl/button_debounce.sv | 41 ++++
 rtl/stopwatch_sequencer.sv | 108 ++++++++++
 tb/tb_stopwatch_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the stopwatch/alarm controller.
// The state encoding is also exported on the debug LED port.
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    localparam int unsigned CS_PER_SEC        = 100;
    localparam logic [15:0] MAX_COUNT_DEFAULT = 16'd59999;

endpackage

// File: rtl/button_debounce.sv
// Active-low button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on the debounced released-to-pressed edge.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Internally everything is pressed-high.
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          db;
    logic          db_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= '0;
            cnt   <= '0;
            db    <= 1'b0;
            db_d  <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], ~btn_n};
            db_d  <= db;
            press <= db & ~db_d;
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db  <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch controller: IDLE/RUN/PAUSE/ALARM FSM, half-speed phase bit,
// latched alarm target and the elapsed-centisecond counter.
module stopwatch_sequencer
    import timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [15:0] MAX_COUNT       = MAX_COUNT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        fast,
    input  logic        ssp,
    input  logic        clr,
    input  logic [8:0]  alarm_sec,
    output logic [15:0] t,
    output logic        running,
    output logic        alarm,
    output logic [1:0]  state
);
    logic        ssp_evt, clr_evt;
    state_t      state_q, state_next;
    logic        phase, phase_next;
    logic [15:0] target, target_next;
    logic [15:0] t_next, t_step;
    logic        step;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ssp_db (
        .clk(clk), .reset(reset), .btn_n(ssp), .press(ssp_evt)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk(clk), .reset(reset), .btn_n(clr), .press(clr_evt)
    );

    always_comb begin
        state_next  = state_q;
        t_next      = t;
        phase_next  = phase;
        target_next = target;
        step        = 1'b0;
        t_step      = (t == MAX_COUNT) ? 16'd0 : t + 16'd1;
        // Half speed steps on the tick that finds phase already set.
        if (state_q == S_RUN && tick) begin
            step = fast | phase;
            if (!fast) phase_next = ~phase;
        end
        unique case (state_q)
            S_IDLE: begin
                t_next     = '0;
                phase_next = 1'b0;
                if (!clr_evt && ssp_evt) begin
                    state_next  = S_RUN;
                    target_next = 16'(alarm_sec) * 16'(CS_PER_SEC);
                end
            end
            S_RUN: begin
                if (clr_evt) begin
                    state_next = S_IDLE;
                    t_next     = '0;
                    phase_next = 1'b0;
                end else begin
                    if (step) t_next = t_step;
                    if (ssp_evt)
                        state_next = S_PAUSE;
                    else if (step && target != '0 && t_step == target)
                        state_next = S_ALARM;
                end
            end
            S_PAUSE: begin
                if (clr_evt) begin
                    state_next = S_IDLE;
                    t_next     = '0;
                    phase_next = 1'b0;
                end else if (ssp_evt) begin
                    state_next = S_RUN;
                end
            end
            S_ALARM: begin
                if (clr_evt || ssp_evt) begin
                    state_next = S_IDLE;
                    t_next     = '0;
                    phase_next = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            t       <= '0;
            phase   <= 1'b0;
            target  <= '0;
            running <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            state_q <= state_next;
            t       <= t_next;
            phase   <= phase_next;
            target  <= target_next;
            running <= (state_next == S_RUN);
            alarm   <= (state_next == S_ALARM);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Randomized plus directed bench for stopwatch_sequencer with a cycle-level
// behavioural model checked on every falling clock edge.
module tb_stopwatch_sequencer;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset, tick, fast, ssp, clr;
    logic [8:0]  alarm_sec;
    logic [15:0] t;
    logic        running, alarm;
    logic [1:0]  state;

    int vectors = 0;
    int misses  = 0;
    int sh = 0;
    int ch = 0;

    stopwatch_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .tick(tick), .fast(fast), .ssp(ssp),
        .clr(clr), .alarm_sec(alarm_sec), .t(t), .running(running),
        .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          s1, s2;
        logic [DB-1:0] hist;   // last DB synchronized samples, pressed = 1
        logic          db, dbp, evt;
    } deb_t;

    typedef struct packed {
        int t;
        int st;      // 0 idle, 1 run, 2 pause, 3 alarm
        bit phase;
        int target;
    } mdl_t;

    deb_t m_ssp, m_clr;
    mdl_t m;

    // Debounced level flips once the last DB synchronized samples all disagree with it.
    function automatic deb_t deb(input deb_t o, input logic pin);
        deb_t n;
        n      = o;
        n.s1   = ~pin;
        n.s2   = o.s1;
        n.hist = {o.hist[DB-2:0], o.s2};
        if (n.hist == {DB{~o.db}}) n.db = ~o.db;
        n.dbp  = o.db;
        n.evt  = o.db & ~o.dbp;
        return n;
    endfunction

    function automatic mdl_t fsm(input mdl_t o, input bit se, input bit ce,
                                 input bit tk, input bit fs, input int asec);
        mdl_t n;
        bit   stp;
        int   nt;
        n   = o;
        stp = (o.st == 1) && tk && (fs || o.phase);
        if (o.st == 1 && tk && !fs) n.phase = !o.phase;
        nt  = stp ? (o.t + 1) % 60000 : o.t;
        case (o.st)
            0: if (!ce && se) begin n.st = 1; n.target = asec * 100; end
            1: if (ce) begin n.st = 0; n.t = 0; n.phase = 0; end
               else begin
                   n.t = nt;
                   if (se) n.st = 2;
                   else if (stp && o.target != 0 && nt == o.target) n.st = 3;
               end
            2: if (ce) begin n.st = 0; n.t = 0; n.phase = 0; end
               else if (se) n.st = 1;
            default: if (ce || se) begin n.st = 0; n.t = 0; n.phase = 0; end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ssp <= '0;
            m_clr <= '0;
            m     <= '0;
        end else begin
            m_ssp <= deb(m_ssp, ssp);
            m_clr <= deb(m_clr, clr);
            m     <= fsm(m, m_ssp.evt, m_clr.evt, tick, fast, int'(alarm_sec));
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misses++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model t", int'(t), m.t);
        chk("model state", int'(state), m.st);
        chk("model running", int'(running), int'(m.st == 1));
        chk("model alarm", int'(alarm), int'(m.st == 3));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        cyc(n);
        tick = 1'b0;
    endtask

    task automatic press_ssp(input int hold);
        ssp = 1'b0;
        cyc(hold);
        ssp = 1'b1;
        cyc(12);
    endtask

    task automatic press_clr(input int hold);
        clr = 1'b0;
        cyc(hold);
        clr = 1'b1;
        cyc(12);
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; fast = 1'b1;
        ssp = 1'b1; clr = 1'b1; alarm_sec = 9'd0;
        cyc(3);
        chk("reset t", int'(t), 0);
        chk("reset state", int'(state), 0);
        reset = 1'b1;
        cyc(2);

        // Start with a clean press, count 5, then a short glitch is ignored.
        press_ssp(8);
        chk("start running", int'(running), 1);
        ticks(5);
        chk("fast t", int'(t), 5);
        ssp = 1'b0; cyc(3); ssp = 1'b1; cyc(12);
        chk("glitch state", int'(state), 1);

        // Half speed, pause keeps t and phase.
        press_clr(8);
        chk("clear t", int'(t), 0);
        fast = 1'b0;
        press_ssp(8);
        ticks(3);
        chk("half t", int'(t), 1);
        press_ssp(8);
        chk("pause state", int'(state), 2);
        ticks(4);
        chk("pause t", int'(t), 1);
        press_ssp(8);
        ticks(1);
        chk("resume t", int'(t), 2);

        // Clear beats start/stop in the same cycle.
        press_clr(8);
        fast = 1'b1;
        press_ssp(8);
        ticks(12);
        press_ssp(8);
        chk("pre-clr t", int'(t), 12);
        ssp = 1'b0; clr = 1'b0; cyc(8); ssp = 1'b1; clr = 1'b1; cyc(12);
        chk("clr prio state", int'(state), 0);
        chk("clr prio t", int'(t), 0);

        // Alarm at 1 s, held, then dismissed.
        alarm_sec = 9'd1;
        press_ssp(8);
        ticks(100);
        chk("alarm t", int'(t), 100);
        chk("alarm flag", int'(alarm), 1);
        chk("alarm state", int'(state), 3);
        ticks(5);
        chk("alarm hold t", int'(t), 100);
        press_ssp(8);
        chk("dismiss state", int'(state), 0);
        chk("dismiss alarm", int'(alarm), 0);

        // Asynchronous reset mid-run.
        alarm_sec = 9'd0;
        press_ssp(8);
        ticks(37);
        chk("pre-reset t", int'(t), 37);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("async t", int'(t), 0);
        chk("async state", int'(state), 0);
        chk("async running", int'(running), 0);
        chk("async alarm", int'(alarm), 0);
        ssp = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(10);
        ssp = 1'b1;
        cyc(12);
        chk("post-reset start", int'(state), 1);
        press_clr(8);

        // Random traffic against the model.
        alarm_sec = 9'd1;
        for (int i = 0; i < 1500; i++) begin
            tick = ($urandom_range(2) == 0);
            if ($urandom_range(40) == 0) fast = ~fast;
            if ($urandom_range(200) == 0) alarm_sec = 9'($urandom_range(2));
            if (sh > 0) sh--;
            else if ($urandom_range(30) == 0) sh = $urandom_range(12, 1);
            if (ch > 0) ch--;
            else if ($urandom_range(90) == 0) ch = $urandom_range(12, 1);
            ssp = (sh == 0);
            clr = (ch == 0);
            cyc(1);
        end
        tick = 1'b0; ssp = 1'b1; clr = 1'b1;
        cyc(12);

        // Wrap past 9:59.99 with the alarm disabled.
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        alarm_sec = 9'd0;
        fast = 1'b1;
        press_ssp(8);
        ticks(60001);
        chk("wrap t", int'(t), 1);
        chk("wrap running", int'(running), 1);
        chk("wrap alarm", int'(alarm), 0);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
